// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit ripple slice per stage, carry registered between stages.
// Define PIPELINED_CHUNK_ADDER_OVF_EN to add the two's-complement overflow output ovf.

module pipelined_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] addent,
   input  logic [WIDTH-1:0] augend,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / CHUNK;
   // r_b only carries augend chunks 1..STAGES-1, so it has one element and one chunk fewer.
   localparam int NB     = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int BW     = (STAGES > 1) ? WIDTH - CHUNK : 1;

   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
         $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   // r_a[k] holds produced sum chunks 0..k below the still-unconsumed addent chunks.
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_carry;
   logic [WIDTH-1:0]  r_a [STAGES];
   logic [BW-1:0]     r_b [NB];
   logic [CHUNK:0]    w_chunk [STAGES];
   logic              w_advance;

   assign w_advance = !r_vld[STAGES-1] || out_ready;
   assign in_ready  = w_advance;
   assign out_valid = r_vld[STAGES-1];
   assign s         = r_a[STAGES-1];
   assign cout      = r_carry[STAGES-1];

   // Per-stage chunk adders: stage 0 from the ports, later stages from the previous stage.
   always_comb begin
      w_chunk[0] = {1'b0, addent[CHUNK-1:0]} + {1'b0, augend[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};
      for (int k = 1; k < STAGES; k++) begin
         w_chunk[k] = {1'b0, r_a[k-1][k*CHUNK +: CHUNK]}
                    + {1'b0, r_b[k-1][(k-1)*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, r_carry[k-1]};
      end
   end

`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   logic w_last_load;
   logic w_ovf_next;
   logic r_ovf;

   generate
      if (STAGES == 1) begin : g_ovf_one
         assign w_last_load = in_valid;
         assign w_ovf_next  = signed_ovf(addent[WIDTH-1], augend[WIDTH-1], w_chunk[0][CHUNK-1]);
      end else begin : g_ovf_multi
         assign w_last_load = r_vld[STAGES-2];
         assign w_ovf_next  = signed_ovf(r_a[STAGES-2][WIDTH-1], r_b[STAGES-2][BW-1],
                                         w_chunk[STAGES-1][CHUNK-1]);
      end
   endgenerate

   // Overflow flag travels with the final stage so it obeys the same stall rules as s/cout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_advance && w_last_load) begin
         r_ovf <= w_ovf_next;
      end
   end

   assign ovf = r_ovf;
`endif

   // Pipeline registers: everything shifts together on advance, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld   <= '0;
         r_carry <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
         end
         for (int k = 0; k < NB; k++) begin
            r_b[k] <= '0;
         end
      end else if (w_advance) begin
         r_vld[0] <= in_valid;
         if (in_valid) begin
            r_a[0]              <= addent;
            r_a[0][CHUNK-1:0]   <= w_chunk[0][CHUNK-1:0];
            r_b[0]              <= augend[WIDTH-1 -: BW];
            r_carry[0]          <= w_chunk[0][CHUNK];
         end
         for (int k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
               r_a[k]                   <= r_a[k-1];
               r_a[k][k*CHUNK +: CHUNK] <= w_chunk[k][CHUNK-1:0];
               r_carry[k]               <= w_chunk[k][CHUNK];
            end
         end
         for (int k = 1; k < STAGES - 1; k++) begin
            if (r_vld[k-1]) begin
               r_b[k] <= r_b[k-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed bench for pipelined_chunk_adder (defaults WIDTH=16, CHUNK=4): vector table plus
// hand-written sweep, backpressure and mid-flight reset sequences.

module tb_pipelined_chunk_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] addent;
   logic [15:0] augend;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout;
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
   logic        ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] exp_s;
      logic        exp_c;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [10];

   pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .addent    (addent),
      .augend    (augend),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat, then wait (bounded) for its result; latency counts edges after the accept edge.
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      in_valid  = 1'b1;
      addent    = v.a;
      augend    = v.b;
      cin       = v.ci;
      out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int i = 0; i <= 8; i++) begin
         if (out_valid) begin
            lat = i;
            break;
         end
         tick();
      end
      chk({tag, " latency"}, lat, 3);
      if (lat >= 0) begin
         chk({tag, " s"}, s, v.exp_s);
         chk({tag, " cout"}, cout, v.exp_c);
`ifdef PIPELINED_CHUNK_ADDER_OVF_EN
         chk({tag, " ovf"}, ovf, v.exp_ovf);
`endif
         tick();
         chk({tag, " single pulse"}, out_valid, 0);
      end
   endtask

   initial begin
      int          nrcv;
      int          nb;
      int          first;
      int          last;
      logic        acc;
      logic        prev_stall;
      logic [15:0] prev_s;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      addent    = 16'h0000;
      augend    = 16'h0000;
      cin       = 1'b0;
      out_ready = 1'b1;

      vecs[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[8] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
      vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

      #2;
      chk("reset out_valid", out_valid, 0);
      chk("reset s", s, 16'h0000);
      chk("reset cout", cout, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle {out_valid,cout,s}", {out_valid, cout, s}, 0);
         chk("idle in_ready", in_ready, 1);
      end

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back sweep: results must arrive in order on 16 consecutive cycles.
      nrcv  = 0;
      first = -1;
      last  = -1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (cyc < 16) begin
            in_valid = 1'b1;
            addent   = 16'hFFFF;
            augend   = cyc[15:0];
            cin      = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            chk("sweep s", s, nrcv);
            chk("sweep cout", cout, 1);
            if (first < 0) first = cyc;
            last = cyc;
            nrcv++;
         end
      end
      chk("sweep count", nrcv, 16);
      chk("sweep gapless", last - first, 15);

      // Backpressure with bubbles; a junk operand is offered while stalled and must be ignored.
      nrcv       = 0;
      nb         = 0;
      prev_stall = 1'b0;
      prev_s     = 16'h0000;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 6);
         if (nb < 4 && cyc != 2 && cyc != 3) begin
            in_valid = 1'b1;
            addent   = 16'h1234;
            augend   = (out_valid && !out_ready) ? 16'hDEAD : 16'h1111 + nb[15:0];
            cin      = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            chk("bp hold out_valid", out_valid, 1);
            chk("bp hold s", s, prev_s);
         end
         if (out_valid && !out_ready) begin
            chk("bp in_ready during stall", in_ready, 0);
         end
         if (out_valid && out_ready) begin
            chk("bp s", s, 16'h2345 + nrcv);
            nrcv++;
         end
         acc        = in_valid && in_ready;
         prev_stall = out_valid && !out_ready;
         prev_s     = s;
         tick();
         if (acc) nb++;
      end
      chk("bp result count", nrcv, 4);
      out_ready = 1'b1;

      // Mid-flight reset: three ops in the pipe are discarded.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         addent   = 16'h0100;
         augend   = i[15:0];
         cin      = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midreset out_valid async", out_valid, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("midreset no stale out_valid", out_valid, 0);
      end
      run_vec(vecs[1], "after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
Parametrised successor to the 4-bit nibble adder.
- Adds two WIDTH-bit operands plus carry-in using a CHUNK-bit ripple slice per pipeline stage; carry is registered between stages.
- Accepts one operation per cycle, with valid/ready handshake on input and output.
- Used in the arithmetic datapath wherever a wide add must close timing at clock speed.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK (elaboration error otherwise).
CHUNK, 4, bits added per stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands/cin valid this cycle.
in_ready  output  1  block accepts operands this cycle.
addent  input  WIDTH  first operand, unsigned.
augend  input  WIDTH  second operand, unsigned.
cin  input  1  carry-in.
out_valid  output  1  s/cout hold a valid result.
out_ready  input  1  downstream accepts result this cycle.
s  output  WIDTH  sum, addent+augend+cin modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, s, cout and the carry registers clear to 0. Data registers clear to 0.
- Pipeline: STAGES register stages.
  - Stage k (k=0..STAGES-1) adds operand bits [k*CHUNK +: CHUNK] plus the carry from stage k-1. Stage 0 uses cin.
  - Stage k registers the resulting chunk sum and the carry.
  - Upper operand chunks not yet consumed, and lower sum chunks already produced, ride along in the stage registers.
- Latency: a transfer accepted at edge N (in_valid && in_ready) appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1, provided there is no stall. With the defaults: result is visible 4 cycles after acceptance. Final stage registers are the output registers.
- Advance: advance = !out_valid || out_ready. When advance=1, every stage loads from its predecessor, including valid bits. When advance=0, all stages hold.
- in_ready = advance (combinational from out_ready and out_valid; no combinational path from in_valid).
- Throughput: one result per cycle when out_ready is held 1.
- Bubbles: cycles with in_valid=0 and advance=1 insert an invalid slot. Invalid slots propagate but never assert out_valid. A stall freezes bubbles too; there is no bubble collapsing.
- Stall: s/cout/out_valid must remain stable while out_valid=1 and out_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH and the carry is reported only on cout. Example: all-ones + 0 + cin=1 gives s=0, cout=1.
- Reset mid-operation: all in-flight results are discarded; no out_valid is asserted for them after reset releases.
- Operands are sampled only on accepted transfers; operand changes while in_ready=0 are ignored.

Optional Feature:
Macro: PIPELINED_CHUNK_ADDER_OVF_EN
- Defined: adds output port ovf (1 bit), aligned with s/cout and under the same valid/stall rules.
  - ovf = two's-complement signed overflow: the operand MSBs are equal and s MSB differs from them.
  - cin is included in the addition.
  - ovf resets to 0.
- Undefined: no ovf port and no related logic.

Test Plan:
- Reset/idle: hold rst_n=0, then release with in_valid=0 for 10 cycles -> out_valid=0, s=0x0000, cout=0 throughout.
- Carry ripple across all chunks (defaults): addent=0xFFFF, augend=0x0000, cin=1, one beat, out_ready=1 -> exactly 4 cycles later out_valid=1 for one cycle, s=0x0000, cout=1.
- Back-to-back sweep: addent=0xFFFF, cin=1, augend=0..15 on consecutive cycles, out_ready=1 -> 16 consecutive results with s=augend, cout=1, in order, with no gaps.
- Backpressure: stream addent=0x1234, augend=0x1111..0x1114 with cin=0; drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, s stable at its value, results 0x2345..0x2348 delivered in order with none lost or duplicated.
- Reset mid-flight: accept 3 operations, then pulse rst_n low for 1 cycle before the first completes -> out_valid never asserts for those operations; a new op 0x0001+0x0001 gives s=0x0002 after 4 cycles.
- With PIPELINED_CHUNK_ADDER_OVF_EN: 0x7FFF+0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0.
